// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS coefficient adaptation engine:
// state encoding, fixed-point fraction widths and the accumulator clamp.
package lms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ADAPT  = 2'd2,
    ST_HOLD   = 2'd3
  } lms_state_e;

  localparam int DATA_FRAC = 7;
  localparam int ERR_FRAC  = 7;
  localparam int COEF_FRAC = 7;

  // Working width for accumulator arithmetic; wide enough that acc + mu*e*x never wraps.
  localparam int SAT_W = 32;

  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] v,
    input int                      bw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((32'd1 << (bw - 1)) - 32'd1);
    lo = -hi - 32'sd1;
    if (v > hi) begin
      sat_clamp = hi;
    end else if (v < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = v;
    end
  endfunction

endpackage

// File: rtl/lms_coef_update_tap.sv
// One LMS tap: acc <= sat(acc + (e*x >>> mu)), with preload and a parameterised reset value.
// Optional leakage term enabled by the LMS_LEAK_EN macro.
module lms_tap
  import lms_pkg::*;
#(
  parameter int IN_BW   = 11,
  parameter int ERR_BW  = 9,
  parameter int COEF_BW = 9,
  parameter int ACC_EXT = 7,
`ifdef LMS_LEAK_EN
  parameter int LEAK_SHIFT = 12,
`endif
  parameter logic [COEF_BW+ACC_EXT-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_update,
  input  logic               i_load,
  input  logic [IN_BW-1:0]   i_x,
  input  logic [ERR_BW-1:0]  i_err,
  input  logic [3:0]         i_mu,
  input  logic [COEF_BW-1:0] i_init,
  output logic [COEF_BW-1:0] o_coef,
  output logic               o_clamp
);

  localparam int ACC_BW    = COEF_BW + ACC_EXT;
  localparam int P_BW      = IN_BW + ERR_BW;
  localparam int PROD_FRAC = DATA_FRAC + ERR_FRAC;
  localparam int ACC_FRAC  = COEF_FRAC + ACC_EXT;
  // Accumulator is assumed to carry at least as many fraction bits as the product.
  localparam int ALIGN     = (ACC_FRAC >= PROD_FRAC) ? (ACC_FRAC - PROD_FRAC) : 0;

  logic signed [ACC_BW-1:0] acc_q;
  logic signed [ACC_BW-1:0] acc_d;
  logic signed [P_BW-1:0]   prod;
  logic signed [SAT_W-1:0]  acc_ext;
  logic signed [SAT_W-1:0]  d_ext;
  logic signed [SAT_W-1:0]  sum_ext;
  logic signed [SAT_W-1:0]  sat_ext;

  assign prod    = $signed(i_x) * $signed(i_err);
  assign acc_ext = SAT_W'(acc_q);
  assign d_ext   = (SAT_W'(prod) <<< ALIGN) >>> i_mu;

`ifdef LMS_LEAK_EN
  assign sum_ext = acc_ext + d_ext - (acc_ext >>> LEAK_SHIFT);
`else
  assign sum_ext = acc_ext + d_ext;
`endif

  assign sat_ext = sat_clamp(sum_ext, ACC_BW);
  assign acc_d   = sat_ext[ACC_BW-1:0];
  assign o_clamp = i_update && (sat_ext != sum_ext);
  assign o_coef  = acc_q[ACC_BW-1:ACC_EXT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= RST_VAL;
    end else if (i_load) begin
      acc_q <= {i_init, {ACC_EXT{1'b0}}};
    end else if (i_update) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/lms_coef_update.sv
// LMS adaptation engine producing the packed S(9,7) coefficient bus for the FFE.
// Build option: define LMS_LEAK_EN to add per-tap leakage (acc >>> LEAK_SHIFT).
module lms_coef_update
  import lms_pkg::*;
#(
  parameter int IN_BW      = 11,
  parameter int ERR_BW     = 9,
  parameter int COEF_BW    = 9,
  parameter int N_COEF     = 7,
  parameter int ACC_EXT    = 7,
  parameter int ERR_LAT    = 3
`ifdef LMS_LEAK_EN
  ,
  parameter int LEAK_SHIFT = 12
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [IN_BW-1:0]          i_data,
  input  logic [ERR_BW-1:0]         i_err,
  input  logic [3:0]                i_mu,
  input  logic                      i_adapt,
  input  logic                      i_load,
  input  logic [COEF_BW*N_COEF-1:0] i_init_coefs,
  output logic [COEF_BW*N_COEF-1:0] o_coefs,
  output logic                      o_adapting,
  output logic                      o_sat
);

  localparam int ACC_BW   = COEF_BW + ACC_EXT;
  // Only stages feeding a tap are kept; the deepest tap reads DL_LEN-1.
  localparam int DL_LEN   = ERR_LAT + N_COEF - 1;
  localparam int WARM_LEN = ERR_LAT + N_COEF - 1;
  localparam int CNT_BW   = $clog2(WARM_LEN + 1);
  localparam int CENTER   = (N_COEF - 1) / 2;
  localparam logic [ACC_BW-1:0] SPIKE = ACC_BW'(1) << (COEF_FRAC + ACC_EXT);

  logic [IN_BW-1:0]  dl_q [DL_LEN];
  lms_state_e        state_q;
  logic [CNT_BW-1:0] cnt_q;
  logic              adapting_q;
  logic              sat_q;
  logic              upd;
  logic [N_COEF-1:0] clamp_w;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DL_LEN; i++) dl_q[i] <= '0;
    end else if (i_en) begin
      dl_q[0] <= i_data;
      for (int i = 1; i < DL_LEN; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      adapting_q <= 1'b0;
    end else if (i_load) begin
      state_q    <= i_adapt ? ST_WARMUP : ST_IDLE;
      cnt_q      <= '0;
      adapting_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_adapt) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
          end
        end
        ST_WARMUP: begin
          if (!i_adapt) begin
            state_q <= ST_IDLE;
          end else if (i_en) begin
            if (cnt_q == CNT_BW'(WARM_LEN - 1)) begin
              state_q    <= ST_ADAPT;
              adapting_q <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ADAPT: begin
          if (!i_adapt) begin
            state_q    <= ST_HOLD;
            adapting_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (i_adapt) begin
            state_q    <= ST_ADAPT;
            adapting_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          adapting_q <= 1'b0;
        end
      endcase
    end
  end

  assign upd = (state_q == ST_ADAPT) && i_en && !i_load;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      sat_q <= 1'b0;
    end else if (|clamp_w) begin
      sat_q <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_COEF; gi++) begin : g_tap
      logic [IN_BW-1:0] x_w;
      if (ERR_LAT + gi == 0) begin : g_direct
        assign x_w = i_data;
      end else begin : g_dl
        assign x_w = dl_q[ERR_LAT+gi-1];
      end

      lms_tap #(
        .IN_BW   (IN_BW),
        .ERR_BW  (ERR_BW),
        .COEF_BW (COEF_BW),
        .ACC_EXT (ACC_EXT),
`ifdef LMS_LEAK_EN
        .LEAK_SHIFT (LEAK_SHIFT),
`endif
        .RST_VAL ((gi == CENTER) ? SPIKE : '0)
      ) u_tap (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_update (upd),
        .i_load   (i_load),
        .i_x      (x_w),
        .i_err    (i_err),
        .i_mu     (i_mu),
        .i_init   (i_init_coefs[gi*COEF_BW +: COEF_BW]),
        .o_coef   (o_coefs[gi*COEF_BW +: COEF_BW]),
        .o_clamp  (clamp_w[gi])
      );
    end
  endgenerate

  assign o_adapting = adapting_q;
  assign o_sat      = sat_q;

endmodule
